pdp8_intctl: RTL and testbench

- CPU-side interrupt controller for the PDP-8 IOT bus, device code 00.
- Collects interrupt requests from the IOT devices (KW8/I clock, TTY, RF08, etc.), gates them with the ION flag, the delayed-enable window and the CIF inhibit, and presents one request to the CPU at end of instruction.
- Executes the IOT 600x group (SKON/ION/IOF/SRQ/GTF/RTF/CAF) using the same F1-sampled select/skip protocol as the other devices.

---
 rtl/pdp8_defs.sv | 32 +++
 rtl/pdp8_prio_enc.sv | 18 +
 rtl/pdp8_intctl.sv | 157 +++++++++++++++
 tb/tb_pdp8_intctl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_defs.sv
// Shared constants for the PDP-8 CPU-side interrupt controller:
// major state codes, IOT 600x function codes, device code and GTF bit map.
package pdp8_defs;

  // CPU major states
  localparam logic [3:0] ST_F0 = 4'd0;
  localparam logic [3:0] ST_F1 = 4'd1;
  localparam logic [3:0] ST_F2 = 4'd2;
  localparam logic [3:0] ST_F3 = 4'd3;

  // IOT 600x function codes (mb[2:0])
  localparam logic [2:0] IOT_SKON = 3'd0;
  localparam logic [2:0] IOT_ION  = 3'd1;
  localparam logic [2:0] IOT_IOF  = 3'd2;
  localparam logic [2:0] IOT_SRQ  = 3'd3;
  localparam logic [2:0] IOT_GTF  = 3'd4;
  localparam logic [2:0] IOT_RTF  = 3'd5;
  localparam logic [2:0] IOT_NOP6 = 3'd6;
  localparam logic [2:0] IOT_CAF  = 3'd7;

  // Device code owned by the interrupt controller
  localparam logic [5:0] DEV_INT = 6'o00;

  // GTF word bit positions
  localparam int GTF_IRQ = 7;
  localparam int GTF_II  = 6;
  localparam int GTF_ION = 5;

  // ION/RTF delay load: one full instruction must complete before interrupts
  localparam logic [1:0] DELAY_RELOAD = 2'd2;

endpackage

// File: rtl/pdp8_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req (0 when idle).
module pdp8_prio_enc #(
  parameter int NIRQ  = 8,
  parameter int SRC_W = 3
) (
  input  logic [NIRQ-1:0]  req,
  output logic [SRC_W-1:0] src
);

  // Scan from the lowest-priority end so the lowest set index is written last
  always_comb begin
    src = {SRC_W{1'b0}};
    for (int i = NIRQ - 1; i >= 0; i--) begin
      src = req[i] ? SRC_W'(i) : src;
    end
  end

endmodule

// File: rtl/pdp8_intctl.sv
// PDP-8 interrupt controller on device code 00: ION/delay/CIF gating of the
// device request lines, and execution of the IOT 600x group.
module pdp8_intctl
  import pdp8_defs::*;
#(
  parameter int NIRQ  = 8,
  parameter int SRC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iot,
  input  logic [3:0]       state,
  input  logic [11:0]      mb,
  input  logic [5:0]       io_select,
  input  logic [11:0]      ac,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic             cif_pulse,
  input  logic             jmp_jms,
  input  logic             int_ack,
  output logic             io_selected,
  output logic             io_skip,
  output logic [11:0]      io_data_out,
  output logic             io_data_ld,
  output logic             io_clear_all,
  output logic             int_req,
  output logic [SRC_W-1:0] int_src,
  output logic             ion
);

  logic       sel_s;
  logic [2:0] fn_s;
  logic       any_irq_s;
  logic       is_f3_s;

  logic       ion_r;
  logic [1:0] delay_r;
  logic       inhibit_r;
  logic       clear_r;

  logic       ion_s;
  logic [1:0] delay_s;
  logic       inhibit_s;
  logic       clear_s;

  assign sel_s     = iot && (state == ST_F1) && (io_select == DEV_INT);
  assign fn_s      = mb[2:0];
  assign any_irq_s = |irq_in;
  assign is_f3_s   = (state == ST_F3);

  // Bus responses of the selected IOT; all quiet when not addressed in F1
  always_comb begin
    io_selected = sel_s;
    io_skip     = 1'b0;
    io_data_out = 12'o0000;
    io_data_ld  = 1'b0;
    if (sel_s) begin
      case (fn_s)
        IOT_SKON: io_skip = ion_r;
        IOT_SRQ:  io_skip = any_irq_s;
        IOT_GTF: begin
          io_data_ld           = 1'b1;
          io_data_out[GTF_IRQ] = any_irq_s;
          io_data_out[GTF_II]  = inhibit_r;
          io_data_out[GTF_ION] = ion_r;
        end
        default:  io_skip = 1'b0;
      endcase
    end else begin
      io_skip = 1'b0;
    end
  end

  // Next register values; later assignments carry higher precedence
  always_comb begin
    ion_s     = ion_r;
    delay_s   = delay_r;
    inhibit_s = inhibit_r;
    clear_s   = 1'b0;
    // delay window counts down once per completed instruction
    if (is_f3_s && (delay_r != 2'd0)) begin
      delay_s = delay_r - 2'd1;
    end else begin
      delay_s = delay_r;
    end
    // a JMP/JMS ends the CIF inhibit window
    if (is_f3_s && jmp_jms) begin
      inhibit_s = 1'b0;
    end else begin
      inhibit_s = inhibit_r;
    end
    if (sel_s) begin
      case (fn_s)
        IOT_SKON: ion_s = 1'b0;
        IOT_ION: begin
          ion_s   = 1'b1;
          delay_s = DELAY_RELOAD;
        end
        IOT_IOF:  ion_s = 1'b0;
        IOT_RTF: begin
          ion_s     = ac[5];
          delay_s   = DELAY_RELOAD;
          inhibit_s = 1'b0;
        end
        IOT_CAF: begin
          ion_s     = 1'b0;
          delay_s   = 2'd0;
          inhibit_s = 1'b0;
          clear_s   = 1'b1;
        end
        default:  ion_s = ion_r;
      endcase
    end else begin
      clear_s = 1'b0;
    end
    // CIF always re-arms the inhibit, even against a coincident clear
    if (cif_pulse) begin
      inhibit_s = 1'b1;
    end else begin
      inhibit_s = inhibit_s;
    end
    // the CPU entering the interrupt overrides any enable in the same cycle
    if (int_ack) begin
      ion_s   = 1'b0;
      delay_s = 2'd0;
    end else begin
      ion_s   = ion_s;
    end
  end

  // Controller state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ion_r     <= 1'b0;
      delay_r   <= 2'd0;
      inhibit_r <= 1'b0;
      clear_r   <= 1'b0;
    end else begin
      ion_r     <= ion_s;
      delay_r   <= delay_s;
      inhibit_r <= inhibit_s;
      clear_r   <= clear_s;
    end
  end

  assign ion          = ion_r;
  assign io_clear_all = clear_r;
  assign int_req      = ion_r && (delay_r == 2'd0) && !inhibit_r && any_irq_s;

  pdp8_prio_enc #(
    .NIRQ  (NIRQ),
    .SRC_W (SRC_W)
  ) u_prio (
    .req (irq_in),
    .src (int_src)
  );

endmodule

// File: tb/tb_pdp8_intctl.sv
// Scoreboard bench for pdp8_intctl: a stimulus process drives CPU instruction
// sequences and queues the expected outputs from an instruction-level model;
// a monitor pops and compares on every falling edge.
module tb_pdp8_intctl;

  logic        clk = 1'b0;
  logic        reset, iot, cif_pulse, jmp_jms, int_ack;
  logic [3:0]  state;
  logic [11:0] mb, ac;
  logic [5:0]  io_select;
  logic [7:0]  irq_in;
  logic        io_selected, io_skip, io_data_ld, io_clear_all, int_req, ion_o;
  logic [11:0] io_data_out;
  logic [2:0]  int_src;

  always #5 clk = ~clk;

  pdp8_intctl #(.NIRQ(8), .SRC_W(3)) dut (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_select(io_select), .ac(ac), .irq_in(irq_in), .cif_pulse(cif_pulse),
    .jmp_jms(jmp_jms), .int_ack(int_ack), .io_selected(io_selected),
    .io_skip(io_skip), .io_data_out(io_data_out), .io_data_ld(io_data_ld),
    .io_clear_all(io_clear_all), .int_req(int_req), .int_src(int_src),
    .ion(ion_o)
  );

  typedef struct packed {
    logic [15:0] cyc;
    logic        sel, skip, ld, req, ion, clr;
    logic [11:0] data;
    logic [2:0]  src;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: ION/RTF enable interrupts from the instruction two after
  // the one that executed it (exactly one more instruction completes first).
  bit   m_ion, m_inh, m_clr;
  int   instr_n = 0;
  int   ok_from = 0;
  int   cyc_n   = 0;
  bit   push_en = 1'b0;
  logic [7:0] irq_v = 8'h00;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare presented outputs with the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   c;
      e = sb.pop_front();
      c = int'(e.cyc);
      chk("io_selected", c, 32'(io_selected),  32'(e.sel));
      chk("io_skip",     c, 32'(io_skip),      32'(e.skip));
      chk("io_data_ld",  c, 32'(io_data_ld),   32'(e.ld));
      chk("io_data_out", c, 32'(io_data_out),  32'(e.data));
      chk("int_req",     c, 32'(int_req),      32'(e.req));
      chk("int_src",     c, 32'(int_src),      32'(e.src));
      chk("ion",         c, 32'(ion_o),        32'(e.ion));
      chk("io_clear_all",c, 32'(io_clear_all), 32'(e.clr));
    end
  end

  task automatic cycle(input logic [3:0] st, input logic io, input logic [11:0] m,
                       input logic [5:0] dev, input logic [11:0] a, input logic c,
                       input logic j, input logic k, input logic r);
    exp_t       e;
    logic       s, any;
    logic [7:0] low;
    @(posedge clk);
    #1;
    state = st; iot = io; mb = m; io_select = dev; ac = a;
    cif_pulse = c; jmp_jms = j; int_ack = k; reset = r; irq_in = irq_v;
    cyc_n++;
    any    = |irq_v;
    s      = io && (st == 4'd1) && (dev == 6'o00);
    e.cyc  = cyc_n[15:0];
    e.sel  = s;
    e.skip = s && (((m[2:0] == 3'd0) && m_ion) || ((m[2:0] == 3'd3) && any));
    e.ld   = s && (m[2:0] == 3'd4);
    e.data = e.ld ? {4'b0000, any, m_inh, m_ion, 5'b00000} : 12'o0000;
    e.req  = m_ion && !m_inh && any && (instr_n >= ok_from);
    e.ion  = m_ion;
    e.clr  = m_clr;
    low    = irq_v & (~irq_v + 8'd1);
    e.src  = 3'd0;
    for (int i = 0; i < 8; i++) if (low == (8'd1 << i)) e.src = 3'(i);
    if (push_en) sb.push_back(e);
    // effect of the coming clock edge
    if (r) begin
      m_ion = 1'b0; m_inh = 1'b0; m_clr = 1'b0; ok_from = 0;
    end else begin
      m_clr = s && (m[2:0] == 3'd7);
      if (s) begin
        case (m[2:0])
          3'd0, 3'd2: m_ion = 1'b0;
          3'd1: begin m_ion = 1'b1; ok_from = instr_n + 2; end
          3'd5: begin m_ion = a[5]; ok_from = instr_n + 2; m_inh = 1'b0; end
          3'd7: begin m_ion = 1'b0; ok_from = 0; m_inh = 1'b0; end
          default: ;
        endcase
      end
      if (st == 4'd3 && j) m_inh = 1'b0;
      if (c) m_inh = 1'b1;
      if (k) begin m_ion = 1'b0; ok_from = 0; end
    end
    if (st == 4'd3) instr_n++;
  endtask

  // One instruction F0..F3; jmp_jms outside F3 is randomised noise
  task automatic instr(input logic io, input logic [2:0] fn, input logic [5:0] dev,
                       input logic [11:0] a, input logic jmp, input int cif_at,
                       input int ack_at, input int rst_at);
    logic [11:0] m;
    m = {9'($urandom), fn};
    for (int s = 0; s < 4; s++) begin
      cycle(4'(s), io, m, dev, a, cif_at == s, (s == 3) ? jmp : 1'($urandom),
            ack_at == s, rst_at == s);
    end
  endtask

  task automatic iotx(input logic [2:0] fn, input logic [11:0] a);
    instr(1'b1, fn, 6'o00, a, 1'b0, -1, -1, -1);
  endtask

  task automatic nop(input logic jmp);
    instr(1'b0, 3'd0, 6'o00, 12'o0000, jmp, -1, -1, -1);
  endtask

  initial begin
    reset = 1'b1; iot = 1'b0; state = 4'd0; mb = 12'o0; io_select = 6'o0;
    ac = 12'o0; cif_pulse = 1'b0; jmp_jms = 1'b0; int_ack = 1'b0; irq_in = 8'h00;
    cycle(4'd0, 1'b0, 12'o0, 6'o77, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_en = 1'b1;
    cycle(4'd0, 1'b0, 12'o0, 6'o77, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ION then NOP with irq 3 held: request appears only after the NOP
    irq_v = 8'b0000_1000;
    iotx(3'd1, 12'o0);
    nop(1'b0);
    nop(1'b0);
    // acknowledge, then SKON must not skip
    instr(1'b0, 3'd0, 6'o00, 12'o0, 1'b0, -1, 0, -1);
    iotx(3'd0, 12'o0);
    // CIF inhibit released only by a JMP/JMS
    irq_v = 8'b0000_0001;
    iotx(3'd1, 12'o0);
    nop(1'b0);
    instr(1'b0, 3'd0, 6'o00, 12'o0, 1'b0, 1, -1, -1);
    nop(1'b0);
    nop(1'b0);
    nop(1'b1);
    nop(1'b0);
    // GTF / RTF with two pending requests
    irq_v = 8'b0010_0100;
    iotx(3'd4, 12'o0);
    iotx(3'd5, 12'o0000);
    iotx(3'd4, 12'o0);
    iotx(3'd5, 12'o0040);
    nop(1'b0);
    nop(1'b0);
    iotx(3'd4, 12'o0);
    // CAF
    iotx(3'd7, 12'o0);
    nop(1'b0);
    // reset mid-delay with inhibit set, then SRQ with no requests
    iotx(3'd1, 12'o0);
    instr(1'b0, 3'd0, 6'o00, 12'o0, 1'b0, 0, -1, 1);
    nop(1'b0);
    irq_v = 8'h00;
    iotx(3'd3, 12'o0);
    // randomised instruction stream
    for (int n = 0; n < 400; n++) begin
      int   cif_at, ack_at, rst_at;
      logic io;
      logic [5:0] dev;
      irq_v  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      io     = ($urandom_range(0, 3) != 0);
      dev    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'o00;
      cif_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
      ack_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
      rst_at = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 3)) : -1;
      instr(io, 3'($urandom), dev, 12'($urandom), 1'($urandom), cif_at, ack_at, rst_at);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", cyc_n, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
